ans_decode_controller: RTL and testbench
========================================

# ans_decode_controller

Sequencer for the ANS symbol decoder in the camera-decoder path. It loads the decoder's 256-entry decode/state tables from a config stream and runs the decode loop. The loop holds the ANS state register, feeds it to the decoder, and emits decoded symbols through a valid/ready stream. It renormalizes the state from an input byte stream whenever the state drops below the lower bound L.

## Interface
- STATE_WIDTH, 32, ANS state width; L = 1 << (STATE_WIDTH-1)
- SYMBOL_WIDTH, 4, symbol width
- TABLE_SIZE, 256, decoder table entries (address width 8)
- COUNT_WIDTH, 16, symbol-count width
- RENORM_MAX, STATE_WIDTH/8, max bytes consumed per renormalization
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  pulse: begin table load
- dec_start  in  1  pulse: begin decode
- dec_init_state  in  STATE_WIDTH  initial ANS state, sampled with dec_start
- dec_count  in  COUNT_WIDTH  symbols to decode, sampled with dec_start
- abort  in  1  synchronous abort to IDLE
- cfg_valid / cfg_ready  in / out  1  table-entry handshake
- cfg_symbol  in  SYMBOL_WIDTH ; cfg_state  in  STATE_WIDTH  table entry payload
- tbl_write  out  1 ; tbl_addr  out  8 ; tbl_symbol  out  SYMBOL_WIDTH ; tbl_state  out  STATE_WIDTH  decoder table-load port
- dec_current_state  out  STATE_WIDTH  state presented to decoder
- dec_symbol  in  SYMBOL_WIDTH ; dec_next_state  in  STATE_WIDTH ; dec_symbol_valid  in  1  combinational decoder results
- bs_valid / bs_ready  in / out  1 ; bs_data  in  8  renormalization byte stream
- sym_valid / sym_ready  out / in  1 ; sym_data  out  SYMBOL_WIDTH ; sym_last  out  1  decoded-symbol stream
- busy, table_loaded, load_done, done, err  out  1  status (load_done and done are 1-cycle pulses)

## Operation
- **FSM states:** IDLE, LOAD, DEC, OUT, RENORM, DONE.
- **IDLE**
  - load_start → LOAD; address counter = 0; table_loaded = 0.
  - dec_start with table_loaded=1 → DEC. Latch state_reg = dec_init_state and remaining = dec_count. If dec_count = 0, go to DONE instead.
  - dec_start with table_loaded=0 → set err; stay in IDLE.
  - load_start and dec_start in the same cycle: load wins; dec_start is ignored.
- **LOAD**
  - cfg_ready = 1.
  - Each cfg handshake registers the entry onto tbl_symbol/tbl_state with tbl_addr = counter, and pulses tbl_write on the next cycle. The counter then increments.
  - The handshake at address TABLE_SIZE-1 → IDLE. table_loaded = 1 and load_done pulses in the same cycle as that final tbl_write.
- **DEC**
  - dec_current_state = state_reg (driven in all states).
  - Capture dec_symbol and dec_next_state → OUT.
  - If dec_symbol_valid = 0: set err → DONE.
- **OUT**
  - sym_valid = 1. sym_data = captured symbol. sym_last = (remaining == 1).
  - On sym_ready: remaining decrements. If last → DONE. Otherwise state_reg = captured next_state, then go to RENORM if next_state < L, else DEC.
  - sym_data and sym_last are held stable while sym_valid=1 and sym_ready=0.
- **RENORM**
  - bs_ready = 1.
  - Each byte: state_reg = ((state_reg << 8) | bs_data) truncated to STATE_WIDTH; byte counter increments.
  - Result ≥ L → DEC.
  - Byte counter reaches RENORM_MAX with result still < L → set err → DONE.
- **DONE:** done pulses for 1 cycle → IDLE.
- **err** is sticky. It clears on the next accepted load_start or dec_start.
- **abort**
  - From any state → IDLE next cycle. All valid/ready/tbl_write outputs are deasserted in that cycle.
  - Abort during LOAD leaves table_loaded = 0.
  - Abort elsewhere preserves table_loaded.
- **busy** = state != IDLE.

## Timing
- **Reset values:** all outputs 0; FSM = IDLE; table_loaded = 0; counters = 0; state_reg = 0.
- **Load:** TABLE_SIZE handshakes. The last tbl_write occurs 1 cycle after the final handshake. dec_start is legal in that same cycle, because the decoder write completes at the edge before DEC reads.
- **Decode, no renorm:** 2 cycles/symbol (DEC, OUT) with sym_ready held high.
- **Renorm:** +1 cycle per byte with bs_valid held high.
- **First output:** sym_valid asserts 2 cycles after dec_start.
- **Completion:** done asserts 1 cycle after the last sym handshake.

## Structure
- Package ans_pkg holds:
  - FSM state enum ans_ctrl_state_t.
  - Constant ANS_L (function of STATE_WIDTH).
  - TABLE_SIZE and table address width.
- Single module, no sub-module. The renorm shift is inline in the state_reg update.

## Test plan
- **Table load:** load_start, then 256 entries with symbol i%16, state 0x8000_0000|i, and random cfg_valid gaps → 256 tbl_write pulses, addresses 0..255 in order, load_done once, table_loaded=1.
- **Decode without renorm:** after that load, dec_start with init 0x8000_0005, count 3 → sym_data 5, 5, 5; no bs_ready; sym_last on the 3rd; done 1 cycle after; 6 cycles total with sym_ready=1.
- **Decode with renorm:** table entry 0x12 has state 0x0080_0012. Init 0x8000_0012, count 2, bs_data 0x34 → one byte consumed, state_reg = 0x8000_1234, then 2nd symbol read from index 0x34.
- **Renorm overflow:** next_state 0x0000_0001 and bytes 0x00 → 4 bytes consumed, err=1, done pulses, no further sym_valid.
- **Backpressure:** sym_ready low for 5 cycles → sym_data/sym_last stable, remaining unchanged.
- **Edge cases:**
  - dec_start before any load → err, stays IDLE.
  - abort mid-LOAD at address 100 → IDLE, table_loaded=0.
  - rst asserted mid-DEC → all outputs 0 immediately.
  - dec_count=0 → done next cycle, no sym_valid.

Source files
------------

// File: rtl/ans_decode_controller_pkg.sv
// Shared types and constants for the ANS decode controller: FSM encoding,
// default widths, table geometry and the renormalization lower bound.
package ans_pkg;

    localparam int ANS_STATE_WIDTH  = 32;
    localparam int ANS_SYMBOL_WIDTH = 4;
    localparam int ANS_COUNT_WIDTH  = 16;
    localparam int ANS_TABLE_SIZE   = 256;
    localparam int ANS_ADDR_WIDTH   = $clog2(ANS_TABLE_SIZE);
    localparam int ANS_RENORM_MAX   = ANS_STATE_WIDTH / 8;

    // Lower bound L: a state is normalized exactly when its MSB is set.
    localparam logic [ANS_STATE_WIDTH-1:0] ANS_L = ANS_STATE_WIDTH'(1) << (ANS_STATE_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DEC    = 3'd2,
        S_OUT    = 3'd3,
        S_RENORM = 3'd4,
        S_DONE   = 3'd5
    } ans_ctrl_state_t;

endpackage

// File: rtl/ans_decode_controller_if.sv
// Streams and decoder ports around the ANS decode controller.
// Handshakes: a beat transfers on a rising edge where valid and ready are both 1.
interface ans_decode_controller_if #(
    parameter int STATE_WIDTH  = ans_pkg::ANS_STATE_WIDTH,
    parameter int SYMBOL_WIDTH = ans_pkg::ANS_SYMBOL_WIDTH,
    parameter int ADDR_WIDTH   = ans_pkg::ANS_ADDR_WIDTH
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [SYMBOL_WIDTH-1:0] cfg_symbol;
    logic [STATE_WIDTH-1:0]  cfg_state;

    logic                    tbl_write;
    logic [ADDR_WIDTH-1:0]   tbl_addr;
    logic [SYMBOL_WIDTH-1:0] tbl_symbol;
    logic [STATE_WIDTH-1:0]  tbl_state;

    logic [STATE_WIDTH-1:0]  dec_current_state;
    logic [SYMBOL_WIDTH-1:0] dec_symbol;
    logic [STATE_WIDTH-1:0]  dec_next_state;
    logic                    dec_symbol_valid;

    logic                    bs_valid;
    logic                    bs_ready;
    logic [7:0]              bs_data;

    logic                    sym_valid;
    logic                    sym_ready;
    logic [SYMBOL_WIDTH-1:0] sym_data;
    logic                    sym_last;

    modport master (
        input  cfg_valid, cfg_symbol, cfg_state,
        output cfg_ready,
        output tbl_write, tbl_addr, tbl_symbol, tbl_state,
        output dec_current_state,
        input  dec_symbol, dec_next_state, dec_symbol_valid,
        input  bs_valid, bs_data,
        output bs_ready,
        output sym_valid, sym_data, sym_last,
        input  sym_ready
    );

    modport slave (
        output cfg_valid, cfg_symbol, cfg_state,
        input  cfg_ready,
        input  tbl_write, tbl_addr, tbl_symbol, tbl_state,
        input  dec_current_state,
        output dec_symbol, dec_next_state, dec_symbol_valid,
        output bs_valid, bs_data,
        input  bs_ready,
        input  sym_valid, sym_data, sym_last,
        output sym_ready
    );

endinterface

// File: rtl/ans_decode_controller.sv
// ANS decode sequencer: loads the decoder tables from the cfg stream, then walks
// the state register through decode, symbol output and byte renormalization.
module ans_decode_controller
    import ans_pkg::*;
#(
    parameter int STATE_WIDTH  = ANS_STATE_WIDTH,
    parameter int SYMBOL_WIDTH = ANS_SYMBOL_WIDTH,
    parameter int TABLE_SIZE   = ANS_TABLE_SIZE,
    parameter int COUNT_WIDTH  = ANS_COUNT_WIDTH,
    parameter int RENORM_MAX   = STATE_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   dec_start,
    input  logic [STATE_WIDTH-1:0] dec_init_state,
    input  logic [COUNT_WIDTH-1:0] dec_count,
    input  logic                   abort,
    ans_decode_controller_if.master bus,
    output logic                   busy,
    output logic                   table_loaded,
    output logic                   load_done,
    output logic                   done,
    output logic                   err,
    output ans_ctrl_state_t        dbg_state
);

    localparam int AW = $clog2(TABLE_SIZE);
    localparam int BW = $clog2(RENORM_MAX + 1);

    ans_ctrl_state_t         state;
    logic [AW-1:0]           tbl_cnt;
    logic [BW-1:0]           byte_cnt;
    logic [COUNT_WIDTH-1:0]  remaining;
    logic [STATE_WIDTH-1:0]  state_reg;
    logic [STATE_WIDTH-1:0]  ns_cap;
    logic                    cfg_ready_q, tbl_write_q, bs_ready_q, sym_valid_q, sym_last_q;
    logic [AW-1:0]           tbl_addr_q;
    logic [SYMBOL_WIDTH-1:0] tbl_symbol_q, sym_data_q;
    logic [STATE_WIDTH-1:0]  tbl_state_q;
    logic [STATE_WIDTH-1:0]  shifted;

    assign shifted               = {state_reg[STATE_WIDTH-9:0], bus.bs_data};
    assign bus.cfg_ready         = cfg_ready_q;
    assign bus.tbl_write         = tbl_write_q;
    assign bus.tbl_addr          = tbl_addr_q;
    assign bus.tbl_symbol        = tbl_symbol_q;
    assign bus.tbl_state         = tbl_state_q;
    assign bus.dec_current_state = state_reg;
    assign bus.bs_ready          = bs_ready_q;
    assign bus.sym_valid         = sym_valid_q;
    assign bus.sym_data          = sym_data_q;
    assign bus.sym_last          = sym_last_q;
    assign busy                  = (state != S_IDLE);
    assign dbg_state             = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            tbl_cnt      <= '0;
            byte_cnt     <= '0;
            remaining    <= '0;
            state_reg    <= '0;
            ns_cap       <= '0;
            cfg_ready_q  <= 1'b0;
            tbl_write_q  <= 1'b0;
            tbl_addr_q   <= '0;
            tbl_symbol_q <= '0;
            tbl_state_q  <= '0;
            bs_ready_q   <= 1'b0;
            sym_valid_q  <= 1'b0;
            sym_data_q   <= '0;
            sym_last_q   <= 1'b0;
            table_loaded <= 1'b0;
            load_done    <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            tbl_write_q <= 1'b0;
            load_done   <= 1'b0;
            done        <= 1'b0;
            if (abort) begin
                state       <= S_IDLE;
                cfg_ready_q <= 1'b0;
                bs_ready_q  <= 1'b0;
                sym_valid_q <= 1'b0;
                if (state == S_LOAD) table_loaded <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // load_start has priority; a simultaneous dec_start is dropped
                        if (load_start) begin
                            state        <= S_LOAD;
                            tbl_cnt      <= '0;
                            table_loaded <= 1'b0;
                            cfg_ready_q  <= 1'b1;
                            err          <= 1'b0;
                        end else if (dec_start) begin
                            if (!table_loaded) begin
                                err <= 1'b1;
                            end else begin
                                err       <= 1'b0;
                                state_reg <= dec_init_state;
                                remaining <= dec_count;
                                if (dec_count == '0) begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= S_DEC;
                                end
                            end
                        end
                    end
                    S_LOAD: begin
                        if (bus.cfg_valid && cfg_ready_q) begin
                            tbl_write_q  <= 1'b1;
                            tbl_addr_q   <= tbl_cnt;
                            tbl_symbol_q <= bus.cfg_symbol;
                            tbl_state_q  <= bus.cfg_state;
                            tbl_cnt      <= tbl_cnt + 1'b1;
                            if (tbl_cnt == AW'(TABLE_SIZE - 1)) begin
                                state        <= S_IDLE;
                                cfg_ready_q  <= 1'b0;
                                table_loaded <= 1'b1;
                                load_done    <= 1'b1;
                            end
                        end
                    end
                    S_DEC: begin
                        ns_cap <= bus.dec_next_state;
                        if (!bus.dec_symbol_valid) begin
                            err   <= 1'b1;
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            sym_data_q  <= bus.dec_symbol;
                            sym_last_q  <= (remaining == COUNT_WIDTH'(1));
                            sym_valid_q <= 1'b1;
                            state       <= S_OUT;
                        end
                    end
                    S_OUT: begin
                        if (bus.sym_ready) begin
                            sym_valid_q <= 1'b0;
                            remaining   <= remaining - 1'b1;
                            if (sym_last_q) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state_reg <= ns_cap;
                                // MSB clear means the next state is below L
                                if (!ns_cap[STATE_WIDTH-1]) begin
                                    state      <= S_RENORM;
                                    bs_ready_q <= 1'b1;
                                    byte_cnt   <= '0;
                                end else begin
                                    state <= S_DEC;
                                end
                            end
                        end
                    end
                    S_RENORM: begin
                        if (bus.bs_valid && bs_ready_q) begin
                            state_reg <= shifted;
                            byte_cnt  <= byte_cnt + 1'b1;
                            if (shifted[STATE_WIDTH-1]) begin
                                state      <= S_DEC;
                                bs_ready_q <= 1'b0;
                            end else if (byte_cnt == BW'(RENORM_MAX - 1)) begin
                                err        <= 1'b1;
                                state      <= S_DONE;
                                done       <= 1'b1;
                                bs_ready_q <= 1'b0;
                            end
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ans_decode_controller.sv
// Directed bench for ans_decode_controller with a behavioural decoder table
// and a symbol scoreboard fed by hand-computed expected values.
module tb_ans_decode_controller;
  import ans_pkg::*;

  logic        clk, rst, load_start, dec_start, abort;
  logic [31:0] dec_init_state;
  logic [15:0] dec_count;
  logic        busy, table_loaded, load_done, done, err;
  ans_ctrl_state_t dbg_state;

  ans_decode_controller_if bus();

  ans_decode_controller dut (
    .clk(clk), .rst(rst), .load_start(load_start), .dec_start(dec_start),
    .dec_init_state(dec_init_state), .dec_count(dec_count), .abort(abort),
    .bus(bus), .busy(busy), .table_loaded(table_loaded), .load_done(load_done),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // decoder stand-in: table written through the load port, read by state low byte
  logic [3:0]  mdl_sym [256];
  logic [31:0] mdl_state [256];
  logic        dec_valid_en;
  always @(posedge clk)
    if (bus.tbl_write) begin
      mdl_sym[bus.tbl_addr]   <= bus.tbl_symbol;
      mdl_state[bus.tbl_addr] <= bus.tbl_state;
    end
  assign bus.dec_symbol       = mdl_sym[bus.dec_current_state[7:0]];
  assign bus.dec_next_state   = mdl_state[bus.dec_current_state[7:0]];
  assign bus.dec_symbol_valid = dec_valid_en;

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  int cyc = 0;
  always @(posedge clk) cyc++;
  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: run did not finish within 20000 cycles");
    $fatal(1);
  end

  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard
  logic [3:0] exp_q[$];
  logic       exp_last_q[$];
  logic [7:0] exp_addr;
  int wr_cnt, ld_cnt, byte_cnt, hs_cnt, done_cnt, sv_cnt;
  int first_sv_cyc, last_hs_cyc, done_cyc, dec_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tbl_write) begin
        check("tbl_addr", bus.tbl_addr, exp_addr);
        exp_addr++;
        wr_cnt++;
      end
      if (load_done) begin
        ld_cnt++;
        check("load_done_with_write", bus.tbl_write, 1'b1);
      end
      if (bus.bs_valid && bus.bs_ready) byte_cnt++;
      if (bus.sym_valid) begin
        sv_cnt++;
        if (first_sv_cyc < 0) first_sv_cyc = cyc;
      end
      if (bus.sym_valid && bus.sym_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        check("sym_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("sym_data", bus.sym_data, exp_q.pop_front());
          check("sym_last", bus.sym_last, exp_last_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] entry_state(input int i, input bit alt);
    if (alt && i == 8'h12) return 32'h0080_0012;
    if (alt && i == 8'h07) return 32'h0000_0001;
    return 32'h8000_0000 | i;
  endfunction

  task automatic do_load(input int n, input bit gaps, input bit alt);
    int i = 0;
    int guard = 0;
    bit hs;
    exp_addr = 0; wr_cnt = 0; ld_cnt = 0;
    load_start = 1;
    tick();
    load_start = 0;
    check("load_clears_err", err, 1'b0);
    while (i < n && guard < 4000) begin
      bus.cfg_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.cfg_symbol = 4'(i % 16);
      bus.cfg_state  = entry_state(i, alt);
      hs = bus.cfg_valid && bus.cfg_ready;
      tick();
      if (hs) i++;
      guard++;
    end
    bus.cfg_valid = 0;
    check("load_handshakes", i, n);
  endtask

  task automatic start_dec(input logic [31:0] init, input logic [15:0] cnt);
    dec_init_state = init;
    dec_count = cnt;
    dec_start = 1;
    byte_cnt = 0; hs_cnt = 0; first_sv_cyc = -1;
    dec_cyc = cyc;
    tick();
    dec_start = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    check(tag, done_cnt - base, 1);
  endtask

  initial begin
    int sv_base;
    int n;
    rst = 1; load_start = 0; dec_start = 0; abort = 0;
    dec_init_state = 0; dec_count = 0; dec_valid_en = 1;
    bus.cfg_valid = 0; bus.cfg_symbol = 0; bus.cfg_state = 0;
    bus.bs_valid = 0; bus.bs_data = 0; bus.sym_ready = 1;
    done_cnt = 0; sv_cnt = 0; exp_addr = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    tick();

    // reset state
    check("rst_busy", busy, 1'b0);
    check("rst_table_loaded", table_loaded, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_sym_valid", bus.sym_valid, 1'b0);
    check("rst_cfg_ready", bus.cfg_ready, 1'b0);
    check("rst_cur_state", bus.dec_current_state, 32'h0);
    check("rst_fsm", dbg_state, S_IDLE);

    // decode before any load
    dec_start = 1;
    tick();
    dec_start = 0;
    check("early_dec_err", err, 1'b1);
    check("early_dec_idle", dbg_state, S_IDLE);

    // abort during load at address 100
    do_load(100, 0, 0);
    abort = 1;
    tick();
    abort = 0;
    check("abort_busy", busy, 1'b0);
    check("abort_table_loaded", table_loaded, 1'b0);
    check("abort_cfg_ready", bus.cfg_ready, 1'b0);
    check("abort_writes", wr_cnt, 100);
    check("abort_no_load_done", ld_cnt, 0);

    // full table load with random gaps
    do_load(256, 1, 0);
    tick();
    check("load_writes", wr_cnt, 256);
    check("load_done_count", ld_cnt, 1);
    check("load_table_loaded", table_loaded, 1'b1);
    check("load_idle", dbg_state, S_IDLE);

    // three symbols, no renormalization
    exp_q.push_back(4'd5); exp_last_q.push_back(1'b0);
    exp_q.push_back(4'd5); exp_last_q.push_back(1'b0);
    exp_q.push_back(4'd5); exp_last_q.push_back(1'b1);
    start_dec(32'h8000_0005, 16'd3);
    wait_done("plain_done", 40);
    check("plain_first_valid", first_sv_cyc - dec_cyc, 2);
    check("plain_total_cycles", last_hs_cyc - dec_cyc, 6);
    check("plain_done_latency", done_cyc - last_hs_cyc, 1);
    check("plain_handshakes", hs_cnt, 3);
    check("plain_no_bytes", byte_cnt, 0);
    check("plain_err", err, 1'b0);

    // zero-length decode
    sv_base = sv_cnt;
    start_dec(32'h8000_0005, 16'd0);
    wait_done("zero_done", 10);
    check("zero_done_latency", done_cyc - dec_cyc, 1);
    check("zero_no_sym_valid", sv_cnt - sv_base, 0);

    // reload with renorm entries; dec_start in the final-write cycle
    do_load(256, 0, 1);
    check("last_write_cycle_write", bus.tbl_write, 1'b1);
    check("last_write_cycle_loaded", table_loaded, 1'b1);
    exp_q.push_back(4'd2); exp_last_q.push_back(1'b0);
    exp_q.push_back(4'd4); exp_last_q.push_back(1'b1);
    bus.bs_valid = 1;
    bus.bs_data = 8'h34;
    start_dec(32'h8000_0012, 16'd2);
    wait_done("renorm_done", 40);
    check("renorm_load_done", ld_cnt, 1);
    check("renorm_bytes", byte_cnt, 1);
    check("renorm_state", bus.dec_current_state, 32'h8000_1234);
    check("renorm_handshakes", hs_cnt, 2);
    check("renorm_err", err, 1'b0);

    // renormalization that never reaches L
    exp_q.push_back(4'd7); exp_last_q.push_back(1'b0);
    bus.bs_data = 8'h00;
    sv_base = sv_cnt;
    start_dec(32'h8000_0007, 16'd2);
    wait_done("ovf_done", 40);
    check("ovf_bytes", byte_cnt, 4);
    check("ovf_err", err, 1'b1);
    check("ovf_handshakes", hs_cnt, 1);
    check("ovf_sym_valid_cycles", sv_cnt - sv_base, 1);
    check("ovf_done_latency", done_cyc - last_hs_cyc, 5);
    bus.bs_valid = 0;

    // backpressure on the symbol stream
    bus.sym_ready = 0;
    exp_q.push_back(4'd9); exp_last_q.push_back(1'b0);
    exp_q.push_back(4'd9); exp_last_q.push_back(1'b1);
    start_dec(32'h8000_0009, 16'd2);
    check("dec_start_clears_err", err, 1'b0);
    n = 0;
    while (!bus.sym_valid && n < 10) begin
      tick();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", bus.sym_valid, 1'b1);
      check("stall_data", bus.sym_data, 4'd9);
      check("stall_last", bus.sym_last, 1'b0);
      check("stall_fsm", dbg_state, S_OUT);
      tick();
    end
    bus.sym_ready = 1;
    wait_done("stall_done", 40);
    check("stall_handshakes", hs_cnt, 2);

    // decoder reports an invalid symbol
    dec_valid_en = 0;
    sv_base = sv_cnt;
    start_dec(32'h8000_0005, 16'd1);
    wait_done("inval_done", 10);
    check("inval_err", err, 1'b1);
    check("inval_no_sym", sv_cnt - sv_base, 0);
    check("inval_latency", done_cyc - dec_cyc, 2);
    dec_valid_en = 1;

    // asynchronous reset in the middle of a decode
    start_dec(32'h8000_0005, 16'd3);
    check("pre_rst_fsm", dbg_state, S_DEC);
    rst = 1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_table_loaded", table_loaded, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_sym_valid", bus.sym_valid, 1'b0);
    check("mid_rst_cur_state", bus.dec_current_state, 32'h0);
    check("mid_rst_fsm", dbg_state, S_IDLE);
    exp_q.delete();
    exp_last_q.delete();
    tick();
    rst = 0;
    tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
